// File: rtl/id_stage_sequencer_if.sv
// id_stage_sequencer_if: decode-stage hazard inputs and sequencing outputs.
interface id_stage_sequencer_if #(parameter int CNT_W = 16);
    logic [15:0]      ifid_instr;
    logic             ifid_valid;
    logic             valid_rt;
    logic             is_halt;
    logic             branch_taken;
    logic             jump;
    logic             idex_mem_en;
    logic             idex_mem_wr;
    logic             idex_reg_wr;
    logic [2:0]       idex_dst_reg;
    logic             mem_busy;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             ctrl_sel;
    logic             pipe_freeze;
    logic             halt_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport slave (
        input  ifid_instr, ifid_valid, valid_rt, is_halt, branch_taken, jump,
               idex_mem_en, idex_mem_wr, idex_reg_wr, idex_dst_reg, mem_busy,
        output pc_write_en, ifid_write_en, ifid_flush, ctrl_sel, pipe_freeze,
               halt_done, stall_cnt, flush_cnt
    );
    modport master (
        output ifid_instr, ifid_valid, valid_rt, is_halt, branch_taken, jump,
               idex_mem_en, idex_mem_wr, idex_reg_wr, idex_dst_reg, mem_busy,
        input  pc_write_en, ifid_write_en, ifid_flush, ctrl_sel, pipe_freeze,
               halt_done, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_stage_sequencer.sv
// id_stage_sequencer: decode-stage stall/flush/freeze arbitration with halt drain
// and saturating stall/flush event counters.
module id_stage_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    id_stage_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {RUN, FREEZE, DRAIN, HALTED} state_t;
    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             halt_done_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             lu, stall_inc, flush_inc;
    logic             pc_we, ifid_we, flush, ctrl, freeze;
    logic [2:0]       rs, rt;
    assign rs = bus.ifid_instr[10:8];
    assign rt = bus.ifid_instr[7:5];
    assign lu = bus.ifid_valid & bus.idex_mem_en & ~bus.idex_mem_wr & bus.idex_reg_wr &
                (bus.idex_dst_reg == rs | (bus.valid_rt & bus.idex_dst_reg == rt));
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        ctrl      = 1'b1;
        flush     = 1'b0;
        freeze    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.mem_busy) begin
                    {pc_we, ifid_we, freeze} = 3'b001;
                    state_d = FREEZE;
                end else if (lu) begin
                    {pc_we, ifid_we, ctrl} = 3'b000;
                    stall_inc = 1'b1;
                end else if (bus.ifid_valid & bus.is_halt) begin
                    {pc_we, ifid_we} = 2'b00;
                    state_d = DRAIN;
                    drain_d = 4'(DRAIN_CYCLES - 1);
                end else if (bus.ifid_valid & (bus.branch_taken | bus.jump)) begin
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                end
            end
            FREEZE: begin
                if (bus.mem_busy) {pc_we, ifid_we, freeze} = 3'b001;
                else state_d = RUN;
            end
            DRAIN: begin
                {pc_we, ifid_we, ctrl} = 3'b000;
                freeze = bus.mem_busy;
                if (!bus.mem_busy) begin
                    if (drain_q == 4'd0) state_d = HALTED;
                    else drain_d = drain_q - 4'd1;
                end
            end
            HALTED: {pc_we, ifid_we, ctrl} = 3'b000;
        endcase
        // While reset is held the outputs sit at their idle values regardless of inputs.
        if (!rst) {pc_we, ifid_we, ctrl, flush, freeze} = 5'b11100;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            drain_q     <= '0;
            halt_done_q <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            halt_done_q <= state_d == HALTED;
            stall_q     <= stall_q + CNT_W'(stall_inc & ~&stall_q);
            flush_q     <= flush_q + CNT_W'(flush_inc & ~&flush_q);
        end
    end
    assign bus.pc_write_en   = pc_we;
    assign bus.ifid_write_en = ifid_we;
    assign bus.ifid_flush    = flush;
    assign bus.ctrl_sel      = ctrl;
    assign bus.pipe_freeze   = freeze;
    assign bus.halt_done     = halt_done_q;
    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;
endmodule

// File: tb/tb_id_stage_sequencer.sv
// tb_id_stage_sequencer: directed and randomized checks of id_stage_sequencer
// against a behavioural model of the sequencing rules.
module tb_id_stage_sequencer;
    localparam int DC  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;
    logic clk, rst;
    int n_cmp = 0, n_bad = 0;
    id_stage_sequencer_if #(.CNT_W(CW)) bus();
    id_stage_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Model: halted flag, bubbles still owed after this one (-1 = not draining),
    // a pending memory freeze, and the two event counts.
    bit m_halted = 0, m_frozen = 0, n_halted, n_frozen;
    int m_drain = -1, m_stall = 0, m_flush = 0, n_drain, n_stall, n_flush;
    bit e_pc, e_ifw, e_ctrl, e_fl, e_frz, e_lu;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (rst) begin
        e_lu = bus.ifid_valid & bus.idex_mem_en & !bus.idex_mem_wr & bus.idex_reg_wr &
               (bus.idex_dst_reg == bus.ifid_instr[10:8] ||
                (bus.valid_rt && bus.idex_dst_reg == bus.ifid_instr[7:5]));
        {e_pc, e_ifw, e_ctrl, e_fl, e_frz} = 5'b11100;
        n_halted = m_halted; n_frozen = m_frozen; n_drain = m_drain;
        n_stall = m_stall; n_flush = m_flush;
        if (m_halted) {e_pc, e_ifw, e_ctrl} = 3'b000;
        else if (m_drain >= 0) begin
            {e_pc, e_ifw, e_ctrl} = 3'b000;
            e_frz = bus.mem_busy;
            if (!bus.mem_busy) begin
                if (m_drain == 0) begin n_halted = 1; n_drain = -1; end
                else n_drain = m_drain - 1;
            end
        end else if (bus.mem_busy) begin
            {e_pc, e_ifw, e_frz} = 3'b001; n_frozen = 1;
        end else if (m_frozen) n_frozen = 0;
        else if (e_lu) begin
            {e_pc, e_ifw, e_ctrl} = 3'b000;
            n_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        end else if (bus.ifid_valid && bus.is_halt) begin
            {e_pc, e_ifw} = 2'b00; n_drain = DC - 1;
        end else if (bus.ifid_valid && (bus.branch_taken || bus.jump)) begin
            e_fl = 1;
            n_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        end
        chk("m.pc_write_en", bus.pc_write_en, e_pc);
        chk("m.ifid_write_en", bus.ifid_write_en, e_ifw);
        chk("m.ctrl_sel", bus.ctrl_sel, e_ctrl);
        chk("m.ifid_flush", bus.ifid_flush, e_fl);
        chk("m.pipe_freeze", bus.pipe_freeze, e_frz);
        chk("m.halt_done", bus.halt_done, m_halted);
        chk("m.stall_cnt", bus.stall_cnt, m_stall);
        chk("m.flush_cnt", bus.flush_cnt, m_flush);
    end
    always @(posedge clk) begin
        if (!rst) begin
            m_halted = 0; m_frozen = 0; m_drain = -1; m_stall = 0; m_flush = 0;
        end else begin
            m_halted = n_halted; m_frozen = n_frozen; m_drain = n_drain;
            m_stall = n_stall; m_flush = n_flush;
        end
    end
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic drive(input logic v, input logic [15:0] ins, input logic vrt, input logic h,
                         input logic b, input logic j, input logic me, input logic mw,
                         input logic rw, input logic [2:0] d, input logic busy);
        bus.ifid_valid = v; bus.ifid_instr = ins; bus.valid_rt = vrt; bus.is_halt = h;
        bus.branch_taken = b; bus.jump = j; bus.idex_mem_en = me; bus.idex_mem_wr = mw;
        bus.idex_reg_wr = rw; bus.idex_dst_reg = d; bus.mem_busy = busy;
    endtask
    task automatic idle();
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    endtask
    task automatic rnd_in();
        drive($urandom_range(9) < 8, 16'($urandom), 1'($urandom), $urandom_range(39) == 0,
              $urandom_range(3) == 0, $urandom_range(9) == 0, 1'($urandom),
              $urandom_range(9) < 3, $urandom_range(9) < 7, 3'($urandom), $urandom_range(4) == 0);
    endtask
    task automatic do_reset();
        rst = 1'b0; rnd_in(); tick(); tick(); rst = 1'b1; idle();
    endtask
    initial begin
        rst = 1'b0;
        rnd_in();
        @(negedge clk);
        chk("rst.pc_write_en", bus.pc_write_en, 1);
        chk("rst.ctrl_sel", bus.ctrl_sel, 1);
        chk("rst.halt_done", bus.halt_done, 0);
        chk("rst.stall_cnt", bus.stall_cnt, 0);
        chk("rst.flush_cnt", bus.flush_cnt, 0);
        tick(); rst = 1'b1; idle();
        // load-use on rs, then rt hit with valid_rt=0
        drive(1, 16'h0300, 0, 0, 0, 0, 1, 0, 1, 3'd3, 0);
        @(negedge clk);
        chk("lu_rs.pc_write_en", bus.pc_write_en, 0);
        chk("lu_rs.ifid_write_en", bus.ifid_write_en, 0);
        chk("lu_rs.ctrl_sel", bus.ctrl_sel, 0);
        tick();
        drive(1, 16'h0160, 0, 0, 0, 0, 1, 0, 1, 3'd3, 0);
        @(negedge clk);
        chk("lu_rs.stall_cnt", bus.stall_cnt, 1);
        chk("rt_novalid.pc_write_en", bus.pc_write_en, 1);
        chk("rt_novalid.ctrl_sel", bus.ctrl_sel, 1);
        tick();
        // branch with load-use, then branch alone
        drive(1, 16'h0300, 0, 0, 1, 0, 1, 0, 1, 3'd3, 0);
        @(negedge clk);
        chk("br_lu.ifid_flush", bus.ifid_flush, 0);
        chk("br_lu.pc_write_en", bus.pc_write_en, 0);
        tick();
        drive(1, 16'h0300, 0, 0, 1, 0, 0, 0, 0, 3'd3, 0);
        @(negedge clk);
        chk("br.ifid_flush", bus.ifid_flush, 1);
        chk("br.pc_write_en", bus.pc_write_en, 1);
        tick(); idle();
        @(negedge clk);
        chk("br.flush_cnt", bus.flush_cnt, 1);
        chk("br.stall_cnt", bus.stall_cnt, 2);
        tick();
        // halt drain
        drive(1, 16'h0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0);
        @(negedge clk);
        chk("halt.ctrl_sel", bus.ctrl_sel, 1);
        chk("halt.pc_write_en", bus.pc_write_en, 0);
        tick(); idle();
        for (int k = 1; k <= DC; k++) begin
            @(negedge clk);
            chk("drain.ctrl_sel", bus.ctrl_sel, 0);
            chk("drain.halt_done", bus.halt_done, 0);
            tick();
        end
        @(negedge clk);
        chk("halted.halt_done", bus.halt_done, 1);
        tick(); rnd_in();
        @(negedge clk);
        chk("halted.halt_done_sticky", bus.halt_done, 1);
        chk("halted.pc_write_en", bus.pc_write_en, 0);
        tick();
        // mem_busy for two cycles mid-drain delays halt_done by two
        do_reset();
        drive(1, 16'h0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0);
        tick();
        for (int k = 1; k <= DC + 2; k++) begin
            drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 3'd0, k == 2 || k == 3);
            @(negedge clk);
            chk("busy_drain.pipe_freeze", bus.pipe_freeze, k == 2 || k == 3);
            chk("busy_drain.halt_done", bus.halt_done, 0);
            tick();
        end
        @(negedge clk);
        chk("busy_drain.halt_done_late", bus.halt_done, 1);
        tick();
        // stall counter saturation
        do_reset();
        drive(1, 16'h0300, 0, 0, 0, 0, 1, 0, 1, 3'd3, 0);
        repeat (20) tick();
        idle();
        @(negedge clk);
        chk("sat.stall_cnt", bus.stall_cnt, 15);
        tick();
        // asynchronous reset mid-drain
        do_reset();
        drive(1, 16'h0300, 0, 0, 0, 0, 1, 0, 1, 3'd3, 0);
        repeat (3) tick();
        drive(1, 16'h0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0);
        tick(); idle(); tick();
        #2 rst = 1'b0;
        #1;
        chk("arst.pc_write_en", bus.pc_write_en, 1);
        chk("arst.ifid_write_en", bus.ifid_write_en, 1);
        chk("arst.ctrl_sel", bus.ctrl_sel, 1);
        chk("arst.halt_done", bus.halt_done, 0);
        chk("arst.stall_cnt", bus.stall_cnt, 0);
        tick(); rst = 1'b1;
        // randomized episodes
        for (int e = 0; e < 12; e++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                rnd_in();
                tick();
            end
        end
        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage_sequencer.md
Name: id_stage_sequencer

Overview:
Pipeline sequencing controller for the decode stage. It owns PC/IF-ID write enables, the control-signal bubble select, the IF/ID flush and the pipeline freeze. It arbitrates among data-memory stalls, load-use hazards, ID-resolved branch/jump redirects and halt, and drains the pipeline after a halt before asserting halt_done. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
DRAIN_CYCLES, 4, cycles of bubbles inserted after halt leaves ID before halt_done; legal range 1..15.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
ifid_instr  input  16  instruction in IF/ID; rs=[10:8], rt=[7:5].
ifid_valid  input  1  IF/ID holds a real instruction.
valid_rt  input  1  instruction reads rt as a source.
is_halt  input  1  IF/ID instruction is halt.
branch_taken  input  1  branch resolved taken in ID.
jump  input  1  jump in ID.
idex_mem_en  input  1  ID/EX memory enable.
idex_mem_wr  input  1  ID/EX memory write.
idex_reg_wr  input  1  ID/EX register write enable.
idex_dst_reg  input  3  ID/EX destination register.
mem_busy  input  1  data memory not ready.
pc_write_en  output  1  PC may update.
ifid_write_en  output  1  IF/ID may load.
ifid_flush  output  1  replace IF/ID with a nop next edge.
ctrl_sel  output  1  1 = normal control into ID/EX, 0 = all-zero bubble.
pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
halt_done  output  1  pipeline drained after halt; registered, sticky.
stall_cnt  output  CNT_W  load-use bubble cycles, saturating.
flush_cnt  output  CNT_W  flush events, saturating.

Behaviour:
- States: RUN, FREEZE, DRAIN, HALTED. On reset (rst=0, asynchronous):
  - state = RUN, drain counter = 0, halt_done = 0, both event counters = 0.
  - Combinational outputs in RUN with no events: pc_write_en = 1, ifid_write_en = 1, ctrl_sel = 1, ifid_flush = 0, pipe_freeze = 0.
- Load-use condition lu:
  - lu = ifid_valid & idex_mem_en & ~idex_mem_wr & idex_reg_wr & (idex_dst_reg==rs | (valid_rt & idex_dst_reg==rt)).
- RUN (Mealy outputs), in priority order:
  1. mem_busy: pipe_freeze = 1, pc_write_en = 0, ifid_write_en = 0, ctrl_sel = 1; next state FREEZE.
  2. lu: pc_write_en = 0, ifid_write_en = 0, ctrl_sel = 0; stall_cnt += 1. Branch, jump and halt are ignored this cycle and are re-evaluated next cycle.
  3. ifid_valid & is_halt: ctrl_sel = 1 (halt enters ID/EX), pc_write_en = 0, ifid_write_en = 0; next state DRAIN with drain counter = DRAIN_CYCLES-1.
  4. ifid_valid & (branch_taken | jump): ifid_flush = 1, pc_write_en = 1; flush_cnt += 1.
  5. Otherwise: default outputs.
- FREEZE: same outputs as RUN step 1 while mem_busy = 1. When mem_busy = 0, outputs are the defaults for that cycle with no hazard evaluation, and the next state is RUN.
- DRAIN: pc_write_en = 0, ifid_write_en = 0, ctrl_sel = 0.
  - If mem_busy: pipe_freeze = 1 and the counter holds.
  - Otherwise the counter decrements. When it reaches 0 with mem_busy = 0, the next state is HALTED.
- HALTED: halt_done = 1 (registered, first asserted the cycle after the last DRAIN cycle). pc_write_en = 0, ifid_write_en = 0, ctrl_sel = 0, pipe_freeze = 0. The block stays here until reset.
- Counters: increment by 1 at the clock edge and saturate at all-ones with no wrap.
- Simultaneous events: mem_busy beats everything; lu beats branch/jump (branch operands are not yet valid); halt beats branch/jump.
- Reset asserted mid-DRAIN or mid-FREEZE returns everything to reset values immediately.

Test Plan:
- Reset: hold rst=0 with random inputs -> pc_write_en=1, ctrl_sel=1, halt_done=0, stall_cnt=0, flush_cnt=0. Release rst -> state RUN.
- Load-use on rs: idex load (mem_en=1, mem_wr=0, reg_wr=1, dst=3), ifid rs=3 -> one cycle with pc_write_en=0, ifid_write_en=0, ctrl_sel=0, stall_cnt=1. Repeat with rt=3 and valid_rt=0 -> no stall.
- Branch with load-use: branch_taken=1 plus lu in the same cycle -> stall only, ifid_flush=0. Next cycle (lu clear) -> ifid_flush=1, flush_cnt=1.
- Halt drain, DRAIN_CYCLES=4: halt in ID at cycle N -> ctrl_sel=1 at N; bubbles at N+1..N+4; halt_done=1 from N+5 onward.
- mem_busy mid-drain: 2 busy cycles during DRAIN -> pipe_freeze=1 for those cycles; halt_done is delayed by exactly 2 cycles.
- Saturation and async reset: CNT_W=4, 20 load-use cycles -> stall_cnt=15. Drop rst asynchronously mid-DRAIN -> outputs return to reset values before the next clock edge.
